// File: rtl/sha256_digest_serializer.sv
// Serializes a 256-bit SHA-256 digest into 32 big-endian bytes over a valid/ready stream.
// Captures on the rising edge of output_valid; rises while a digest is in flight are dropped and flagged.
module sha256_digest_serializer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [255:0]     hash_data,
  input  logic             output_valid,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] digest_count
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q;
  logic [255:0]       data_q, data_d;
  logic [4:0]         idx_q;
  logic               ov_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rise;
  logic               xfer;

  assign rise = output_valid && !ov_q;
  assign xfer = (state_q == SEND) && out_ready;

  // Holding register shifts left on each transfer so the current byte is always the top byte.
  assign data_d = {data_q[247:0], 8'h00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      ov_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ov_q <= output_valid;
      case (state_q)
        IDLE: begin
          if (rise) begin
            data_q  <= hash_data;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (rise) ovf_q <= 1'b1;
          if (xfer) begin
            data_q <= data_d;
            idx_q  <= idx_q + 5'd1;
            if (idx_q == 5'd31) begin
              state_q <= IDLE;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = (state_q == SEND);
  assign busy         = (state_q == SEND);
  assign out_byte     = data_q[255:248];
  assign out_first    = (state_q == SEND) && (idx_q == 5'd0);
  assign out_last     = (state_q == SEND) && (idx_q == 5'd31);
  assign overflow     = ovf_q;
  assign digest_count = cnt_q;

endmodule
